// File: rtl/fx2_fifo_controller_pkg.sv
// Shared definitions for the FX2 slave-FIFO command reader.
package fx2_fifo_controller_pkg;

  localparam int DATA_W = 16;

  // FIFOADDR endpoint select codes.
  localparam logic [1:0] FIFOADDR_EP2 = 2'b00;
  localparam logic [1:0] FIFOADDR_EP4 = 2'b01;
  localparam logic [1:0] FIFOADDR_EP6 = 2'b10;
  localparam logic [1:0] FIFOADDR_EP8 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    OE,
    READ,
    REQ,
    WAIT_ACK_LOW
  } state_t;

endpackage

// File: rtl/fx2_cmd_handshake.sv
// Holding register for one received command word plus its 4-phase
// req/valid flags. The word is loaded only on capture, so it stays stable
// for the whole handshake and until the next read.
module fx2_cmd_handshake
  import fx2_fifo_controller_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_capture,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ack_seen,
  input  logic              i_release,
  output logic [DATA_W-1:0] o_data,
  output logic              o_req,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_data;
  logic              r_req;
  logic              r_valid;

  // Load the word on capture; drop req on ack, drop valid on ack release.
  // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the data register is reset too, so command_rx_data reads 0 out of reset.
      r_data  <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_data  <= i_data;
      r_req   <= 1'b1;
      r_valid <= 1'b1;
    end else begin
      if (i_ack_seen) r_req   <= 1'b0;
      if (i_release)  r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_req   = r_req;
  assign o_valid = r_valid;

endmodule

// File: rtl/fx2_fifo_controller.sv
// Reads single command words from the FX2 EP2 OUT FIFO and hands each one
// to a consumer over a 4-phase req/ack handshake. One word in flight at a
// time: the next SLRD pulse only happens after the consumer has released ack.
// FX2 flags are synchronous to IFCLK, so they are sampled directly.
module fx2_fifo_controller
  import fx2_fifo_controller_pkg::*;
(
  input  logic              fx2_ifclk,
  input  logic              reset_n,
  input  logic              fx2_flaga,
  input  logic              fx2_flagb,
  input  logic              fx2_flagc,
  input  logic              fx2_flagd,
  output logic              fx2_slrd,
  output logic              fx2_slwr,
  output logic              fx2_sloe,
  output logic              fx2_pktend,
  output logic [1:0]        fx2_fifoaddr,
  input  logic [DATA_W-1:0] fx2_fd_in,
  output logic [DATA_W-1:0] fx2_fd_out,
  output logic [DATA_W-1:0] command_rx_data,
  output logic              command_rx_req,
  input  logic              command_rx_ack,
  output logic              command_rx_valid
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_slrd;
  logic              r_sloe;
  logic              r_slwr;
  logic              r_pktend;
  logic [1:0]        r_fifoaddr;
  logic [DATA_W-1:0] r_fd_out;
  logic [2:0]        r_unused_flags;
  logic              w_slrd_next;
  logic              w_sloe_next;
  logic              w_capture;
  logic              w_ack_seen;
  logic              w_release;

  // State register.
  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next state and next strobe values; strobes are registered below.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_slrd_next  = 1'b1;
    w_sloe_next  = 1'b1;
    w_capture    = 1'b0;
    w_ack_seen   = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (fx2_flagb) begin
          w_state_next = OE;
          w_sloe_next  = 1'b0;
        end
      end
      OE: begin
        // Re-check the flag: it may have dropped since IDLE.
        if (fx2_flagb) begin
          w_state_next = READ;
          w_sloe_next  = 1'b0;
          w_slrd_next  = 1'b0;
        end else begin
          w_state_next = IDLE;
        end
      end
      READ: begin
        // SLRD is low during this cycle, so FD holds the word the FX2 pops now.
        w_capture    = 1'b1;
        w_state_next = REQ;
      end
      REQ: begin
        if (command_rx_ack) begin
          w_ack_seen   = 1'b1;
          w_state_next = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        if (!command_rx_ack) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Registered FX2 strobes; write path, PKTEND and endpoint select are fixed.
  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      r_slrd     <= 1'b1;
      r_sloe     <= 1'b1;
      r_slwr     <= 1'b1;
      r_pktend   <= 1'b1;
      r_fifoaddr <= FIFOADDR_EP2;
      r_fd_out   <= '0;
    end else begin
      r_slrd     <= w_slrd_next;
      r_sloe     <= w_sloe_next;
      r_slwr     <= 1'b1;
      r_pktend   <= 1'b1;
      r_fifoaddr <= FIFOADDR_EP2;
      r_fd_out   <= '0;
    end
  end

  // Reserved flags are registered for future use and drive nothing.
  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) r_unused_flags <= '0;
    else          r_unused_flags <= {fx2_flaga, fx2_flagc, fx2_flagd};
  end

  fx2_cmd_handshake u_handshake (
    .i_clk      (fx2_ifclk),
    .i_rst_n    (reset_n),
    .i_capture  (w_capture),
    .i_data     (fx2_fd_in),
    .i_ack_seen (w_ack_seen),
    .i_release  (w_release),
    .o_data     (command_rx_data),
    .o_req      (command_rx_req),
    .o_valid    (command_rx_valid)
  );

  assign fx2_slrd     = r_slrd;
  assign fx2_sloe     = r_sloe;
  assign fx2_slwr     = r_slwr;
  assign fx2_pktend   = r_pktend;
  assign fx2_fifoaddr = r_fifoaddr;
  assign fx2_fd_out   = r_fd_out;

endmodule

// File: tb/tb_fx2_fifo_controller.sv
// Bench for fx2_fifo_controller: a per-cycle vector table for one full
// transaction and the flag race, then directed sequences driven by a small
// FX2 FIFO model (decrementing words) and an optional auto-ack consumer.
module tb_fx2_fifo_controller;
  import fx2_fifo_controller_pkg::*;

  logic        fx2_ifclk = 1'b0;
  logic        reset_n   = 1'b0;
  logic        fx2_flaga = 1'b0;
  logic        fx2_flagc = 1'b0;
  logic        fx2_flagd = 1'b0;
  logic        fx2_flagb;
  logic        fx2_slrd, fx2_slwr, fx2_sloe, fx2_pktend;
  logic [1:0]  fx2_fifoaddr;
  logic [15:0] fx2_fd_in, fx2_fd_out;
  logic [15:0] command_rx_data;
  logic        command_rx_req, command_rx_ack, command_rx_valid;

  // Stimulus controls.
  logic        use_model = 1'b0;
  logic        auto_ack  = 1'b0;
  logic        flagb_man = 1'b0;
  logic        ack_man   = 1'b0;
  logic [15:0] fd_man    = 16'h0000;
  logic        bk_clr    = 1'b1;
  int          load_cnt  = 0;

  // FIFO model and bookkeeping.
  logic [15:0] fifo_word;
  int          words_left;
  int          pulses;
  int          n_deliv;
  logic [15:0] deliv [0:7];
  logic        req_d;
  logic        ack_r;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 fx2_ifclk = ~fx2_ifclk;

  assign fx2_flagb      = use_model ? (words_left != 0) : flagb_man;
  assign fx2_fd_in      = use_model ? fifo_word : fd_man;
  assign command_rx_ack = auto_ack ? ack_r : ack_man;

  fx2_fifo_controller dut (
    .fx2_ifclk        (fx2_ifclk),
    .reset_n          (reset_n),
    .fx2_flaga        (fx2_flaga),
    .fx2_flagb        (fx2_flagb),
    .fx2_flagc        (fx2_flagc),
    .fx2_flagd        (fx2_flagd),
    .fx2_slrd         (fx2_slrd),
    .fx2_slwr         (fx2_slwr),
    .fx2_sloe         (fx2_sloe),
    .fx2_pktend       (fx2_pktend),
    .fx2_fifoaddr     (fx2_fifoaddr),
    .fx2_fd_in        (fx2_fd_in),
    .fx2_fd_out       (fx2_fd_out),
    .command_rx_data  (command_rx_data),
    .command_rx_req   (command_rx_req),
    .command_rx_ack   (command_rx_ack),
    .command_rx_valid (command_rx_valid)
  );

  // FX2 side: pop a word on every edge that sees SLRD low; log deliveries
  // on each req rising edge; the auto-ack consumer echoes req one cycle late.
  always @(posedge fx2_ifclk) begin
    if (bk_clr) begin
      fifo_word  <= 16'hFFFF;
      words_left <= load_cnt;
      pulses     <= 0;
      n_deliv    <= 0;
      req_d      <= 1'b0;
      ack_r      <= 1'b0;
    end else begin
      if (!fx2_slrd) begin
        pulses <= pulses + 1;
        if (use_model && words_left != 0) begin
          fifo_word  <= fifo_word - 16'd1;
          words_left <= words_left - 1;
        end
      end
      if (command_rx_req && !req_d && n_deliv < 8) begin
        deliv[n_deliv] <= command_rx_data;
        n_deliv        <= n_deliv + 1;
      end
      req_d <= command_rx_req;
      ack_r <= command_rx_req;
    end
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load_fifo(input int n);
    @(negedge fx2_ifclk);
    load_cnt = n;
    bk_clr   = 1'b1;
    @(negedge fx2_ifclk);
    bk_clr   = 1'b0;
  endtask

  // {fd_out, data, fifoaddr, slwr, pktend, slrd, sloe, req, valid}
  function automatic logic [47:0] snap();
    return {8'h00, fx2_fd_out, command_rx_data, fx2_fifoaddr, fx2_slwr, fx2_pktend,
            fx2_slrd, fx2_sloe, command_rx_req, command_rx_valid};
  endfunction

  function automatic logic [47:0] expect_of(input logic [15:0] data, input logic [3:0] ctl);
    return {8'h00, 16'h0000, data, 2'b00, 1'b1, 1'b1, ctl};
  endfunction

  typedef struct {
    logic        flagb;
    logic        ack;
    logic [15:0] fd;
    logic [15:0] exp_data;
    logic [3:0]  exp_ctl;   // {slrd, sloe, req, valid} after the edge
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit done;
    int bad;

    // Outputs during the vectors reflect the state reached at that edge.
    vecs[0]  = '{1'b0, 1'b0, 16'h1234, 16'h0000, 4'b1100}; // IDLE, FIFO empty
    vecs[1]  = '{1'b1, 1'b1, 16'h1234, 16'h0000, 4'b1000}; // -> OE, ack high ignored
    vecs[2]  = '{1'b1, 1'b1, 16'hA5C3, 16'h0000, 4'b0000}; // -> READ, SLRD low
    vecs[3]  = '{1'b1, 1'b0, 16'hA5C3, 16'hA5C3, 4'b1111}; // capture -> REQ
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'hA5C3, 4'b1111}; // hold in REQ, data stable
    vecs[5]  = '{1'b1, 1'b1, 16'h0000, 16'hA5C3, 4'b1101}; // ack -> WAIT_ACK_LOW
    vecs[6]  = '{1'b1, 1'b1, 16'h0000, 16'hA5C3, 4'b1101}; // ack still high
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 16'hA5C3, 4'b1100}; // ack low -> IDLE
    vecs[8]  = '{1'b0, 1'b0, 16'h5A5A, 16'hA5C3, 4'b1100}; // empty, stay IDLE
    vecs[9]  = '{1'b1, 1'b0, 16'h5A5A, 16'hA5C3, 4'b1000}; // -> OE
    vecs[10] = '{1'b0, 1'b0, 16'h5A5A, 16'hA5C3, 4'b1100}; // flag race -> IDLE, no SLRD
    vecs[11] = '{1'b0, 1'b0, 16'h5A5A, 16'hA5C3, 4'b1100}; // still idle

    // Reset values after 5 cycles held in reset.
    repeat (5) @(posedge fx2_ifclk);
    #1 check("reset_values", snap(), expect_of(16'h0000, 4'b1100));
    @(negedge fx2_ifclk);
    bk_clr  = 1'b0;
    reset_n = 1'b1;

    // Table-driven single transaction and flag race.
    for (int i = 0; i < 12; i++) begin
      @(negedge fx2_ifclk);
      flagb_man = vecs[i].flagb;
      ack_man   = vecs[i].ack;
      fd_man    = vecs[i].fd;
      {fx2_flaga, fx2_flagc, fx2_flagd} = 3'(i);
      @(posedge fx2_ifclk);
      #1 check($sformatf("vec%0d", i), snap(), expect_of(vecs[i].exp_data, vecs[i].exp_ctl));
    end

    // Empty FIFO: no read activity for 25 cycles.
    use_model = 1'b1;
    load_fifo(0);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge fx2_ifclk);
      #1 if (!fx2_slrd || !fx2_sloe) bad++;
    end
    check("empty_no_activity", 48'(bad), 48'd0);
    check("empty_pulses", 48'(pulses), 48'd0);

    // 3-word burst with auto-ack.
    auto_ack = 1'b1;
    load_fifo(3);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge fx2_ifclk);
      #1 if (n_deliv == 3 && !command_rx_req && !command_rx_valid) done = 1'b1;
    end
    check("burst_complete", 48'(done), 48'd1);
    repeat (20) @(posedge fx2_ifclk);
    #1;
    check("burst_count", 48'(n_deliv), 48'd3);
    check("burst_word0", 48'(deliv[0]), 48'hFFFF);
    check("burst_word1", 48'(deliv[1]), 48'hFFFE);
    check("burst_word2", 48'(deliv[2]), 48'hFFFD);
    check("burst_pulses", 48'(pulses), 48'd3);
    check("burst_idle", {46'd0, fx2_slrd, fx2_sloe}, 48'd3);

    // Ack stall: consumer never acks, one word outstanding for 50 cycles.
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    load_fifo(2);
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge fx2_ifclk);
      #1 if (command_rx_req) done = 1'b1;
    end
    check("stall_req_seen", 48'(done), 48'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge fx2_ifclk);
      #1 if (!command_rx_req || !command_rx_valid || command_rx_data !== 16'hFFFF || !fx2_slrd) bad++;
    end
    check("stall_held", 48'(bad), 48'd0);
    check("stall_pulses", 48'(pulses), 48'd1);

    // Reset in REQ: req/valid drop at once, then the next word reads normally.
    @(negedge fx2_ifclk);
    #2 reset_n = 1'b0;
    #1 check("midreset_async", {44'd0, command_rx_req, command_rx_valid, fx2_slrd, fx2_sloe}, 48'd3);
    @(negedge fx2_ifclk);
    reset_n  = 1'b1;
    auto_ack = 1'b1;
    @(posedge fx2_ifclk);
    #1 check("midreset_first_oe", {46'd0, fx2_sloe, fx2_slrd}, 48'd1);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge fx2_ifclk);
      #1 if (n_deliv == 2 && !command_rx_valid) done = 1'b1;
    end
    check("midreset_next_done", 48'(done), 48'd1);
    check("midreset_next_word", 48'(deliv[1]), 48'hFFFE);
    check("midreset_pulses", 48'(pulses), 48'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
